load_store_unit: RTL and testbench

Memory-stage access sequencer between the EX/MEM pipeline register and `data_memory`. It accepts one load or store request at a time, drives `data_memory`'s `memWrite`/`byte_en`/`address`/`writeData`, and captures `readData`. A misaligned word access (odd address) is split into two byte accesses. It returns load results with a one-cycle valid strobe and holds `ready` low to stall the pipeline while busy.

---
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one load or store at a time into data_memory.
// An odd-address word access can be split into two byte accesses.
//
// Ports:
//   clk           - clock, rising edge
//   reset         - asynchronous, active-low reset
//   req           - request valid, sampled only while ready=1
//   memRead       - request is a load
//   memWrite      - request is a store
//   byteOp        - 1 = byte access, 0 = word access
//   addr          - byte address
//   storeData     - store data (byte stores use [7:0])
//   ready         - high only in IDLE; the pipeline stalls while low
//   loadValid     - one-cycle strobe marking loadData valid
//   loadData      - load result; byte loads are zero-extended
//   reqErr        - one-cycle pulse for a request with both memRead and memWrite
//   mem_memWrite  - write strobe to data_memory
//   mem_byte_en   - byte-mode select to data_memory
//   mem_address   - address to data_memory
//   mem_writeData - write data to data_memory
//   mem_readData  - combinational read data from data_memory
module load_store_unit #(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        byteOp,
    input  logic [15:0] addr,
    input  logic [15:0] storeData,
    output logic        ready,
    output logic        loadValid,
    output logic [15:0] loadData,
    output logic        reqErr,
    output logic        mem_memWrite,
    output logic        mem_byte_en,
    output logic [15:0] mem_address,
    output logic [15:0] mem_writeData,
    input  logic [15:0] mem_readData
);
    typedef enum logic [1:0] {IDLE, ACC_LO, ACC_HI, RESP} state_t;

    state_t      state_q, state_d;
    logic        load_q, load_d;
    logic        split_q, split_d;
    logic        mem_mem_write_q, mem_mem_write_d;
    logic        mem_byte_en_q, mem_byte_en_d;
    logic [15:0] mem_address_q, mem_address_d;
    logic [15:0] mem_write_data_q, mem_write_data_d;
    logic [15:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        req_err_q, req_err_d;

    always_comb begin
        state_d          = state_q;
        load_d           = load_q;
        split_d          = split_q;
        mem_mem_write_d  = mem_mem_write_q;
        mem_byte_en_d    = mem_byte_en_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        load_data_d      = load_data_q;
        load_valid_d     = 1'b0;
        req_err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                req_err_d = req && memRead && memWrite;
                if (req && (memRead ^ memWrite)) begin
                    // Memory-side outputs are registered here so they are
                    // already valid during the ACC_LO cycle.
                    state_d          = ACC_LO;
                    load_d           = memRead;
                    split_d          = SPLIT_MISALIGNED && !byteOp && addr[0];
                    mem_address_d    = addr;
                    mem_write_data_d = storeData;
                    mem_mem_write_d  = memWrite;
                    mem_byte_en_d    = byteOp || split_d;
                end
            end
            ACC_LO: begin
                if (load_q)
                    load_data_d = mem_byte_en_q ? {8'h00, mem_readData[7:0]} : mem_readData;
                if (split_q) begin
                    // Second byte goes to addr+1 (wraps at 16 bits) carrying the high data byte.
                    state_d          = ACC_HI;
                    mem_address_d    = mem_address_q + 16'd1;
                    mem_write_data_d = {8'h00, mem_write_data_q[15:8]};
                end else begin
                    state_d         = load_q ? RESP : IDLE;
                    mem_mem_write_d = 1'b0;
                    mem_byte_en_d   = 1'b0;
                    load_valid_d    = load_q;
                end
            end
            ACC_HI: begin
                if (load_q)
                    load_data_d[15:8] = mem_readData[7:0];
                state_d         = load_q ? RESP : IDLE;
                mem_mem_write_d = 1'b0;
                mem_byte_en_d   = 1'b0;
                load_valid_d    = load_q;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            load_q           <= 1'b0;
            split_q          <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_byte_en_q    <= 1'b0;
            mem_address_q    <= 16'h0000;
            mem_write_data_q <= 16'h0000;
            load_data_q      <= 16'h0000;
            load_valid_q     <= 1'b0;
            req_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            load_q           <= load_d;
            split_q          <= split_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_byte_en_q    <= mem_byte_en_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            load_data_q      <= load_data_d;
            load_valid_q     <= load_valid_d;
            req_err_q        <= req_err_d;
        end
    end

    assign ready         = (state_q == IDLE);
    assign loadValid     = load_valid_q;
    assign loadData      = load_data_q;
    assign reqErr        = req_err_q;
    assign mem_memWrite  = mem_mem_write_q;
    assign mem_byte_en   = mem_byte_en_q;
    assign mem_address   = mem_address_q;
    assign mem_writeData = mem_write_data_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench with a byte-addressed memory model and a load-result scoreboard.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, memRead = 1'b0, memWrite = 1'b0, byteOp = 1'b0;
    logic [15:0] addr = 16'h0000, storeData = 16'h0000;
    logic        ready, loadValid, reqErr, mem_memWrite, mem_byte_en;
    logic [15:0] loadData, mem_address, mem_writeData, mem_readData;

    logic [7:0]  mem [65536];
    logic [15:0] addr_p1;
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .req(req), .memRead(memRead), .memWrite(memWrite),
        .byteOp(byteOp), .addr(addr), .storeData(storeData), .ready(ready),
        .loadValid(loadValid), .loadData(loadData), .reqErr(reqErr),
        .mem_memWrite(mem_memWrite), .mem_byte_en(mem_byte_en), .mem_address(mem_address),
        .mem_writeData(mem_writeData), .mem_readData(mem_readData)
    );

    // Little-endian data_memory model: word = {mem[a+1], mem[a]}.
    assign addr_p1 = mem_address + 16'd1;
    assign mem_readData = mem_byte_en ? {8'h00, mem[mem_address]} : {mem[addr_p1], mem[mem_address]};

    always @(posedge clk) begin
        if (mem_memWrite) begin
            mem[mem_address] <= mem_writeData[7:0];
            if (!mem_byte_en) mem[addr_p1] <= mem_writeData[15:8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (loadValid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_loadValid observed=%h expected=none", loadData);
            end
            if (exp_q.size() != 0) chk("load_data", loadData, exp_q.pop_front());
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_loadValid"}, loadValid, 0);
        chk({tag, "_loadData"}, loadData, 0);
        chk({tag, "_reqErr"}, reqErr, 0);
        chk({tag, "_memWrite"}, mem_memWrite, 0);
        chk({tag, "_byte_en"}, mem_byte_en, 0);
        chk({tag, "_address"}, mem_address, 0);
        chk({tag, "_writeData"}, mem_writeData, 0);
    endtask

    // Waits for ready, drives one request for one edge, then scrambles the
    // non-req inputs to show they are only sampled at the accept edge.
    // Returns at the negedge inside the first cycle after the accept edge.
    task automatic issue(input logic rd, input logic wr, input logic bop,
                         input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp);
        int n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ready, 1);
        req = 1'b1; memRead = rd; memWrite = wr; byteOp = bop; addr = a; storeData = d;
        if (rd && !wr) exp_q.push_back(exp);
        @(negedge clk);
        req = 1'b0;
        memRead = 1'($urandom); memWrite = 1'($urandom); byteOp = 1'($urandom);
        addr = 16'($urandom); storeData = 16'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h56; mem[16'h0001] = 8'h38;
        mem[16'h0004] = 8'h12; mem[16'h0005] = 8'h43;
        mem[16'h0006] = 8'hDE; mem[16'h0007] = 8'hBE;
        mem[16'hFFFF] = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;
        @(negedge clk);

        // Aligned load at 0004.
        issue(1, 0, 0, 16'h0004, 16'h0000, 16'h4312);
        chk("al_acc_addr", mem_address, 16'h0004);
        chk("al_acc_be", mem_byte_en, 0);
        chk("al_acc_wr", mem_memWrite, 0);
        chk("al_acc_ready", ready, 0);
        @(negedge clk);
        chk("al_valid", loadValid, 1);
        chk("al_resp_ready", ready, 0);
        @(negedge clk);
        chk("al_ready_back", ready, 1);
        chk("al_valid_off", loadValid, 0);

        // Split load at 0005.
        issue(1, 0, 0, 16'h0005, 16'h0000, 16'hDE43);
        chk("sl_lo_addr", mem_address, 16'h0005);
        chk("sl_lo_be", mem_byte_en, 1);
        @(negedge clk);
        chk("sl_hi_addr", mem_address, 16'h0006);
        chk("sl_hi_be", mem_byte_en, 1);
        chk("sl_hi_ready", ready, 0);
        @(negedge clk);
        chk("sl_valid", loadValid, 1);
        chk("sl_resp_ready", ready, 0);
        @(negedge clk);
        chk("sl_ready_back", ready, 1);

        // Byte load at 0007.
        issue(1, 0, 1, 16'h0007, 16'h0000, 16'h00BE);
        chk("bl_be", mem_byte_en, 1);
        @(negedge clk);
        chk("bl_valid", loadValid, 1);

        // Word load at FFFF wraps to 0000 for the high byte.
        issue(1, 0, 0, 16'hFFFF, 16'h0000, 16'h5600);
        chk("wr_lo_addr", mem_address, 16'hFFFF);
        @(negedge clk);
        chk("wr_hi_addr", mem_address, 16'h0000);
        @(negedge clk);
        chk("wr_valid", loadValid, 1);

        // Split store ABCD at 0009.
        issue(0, 1, 0, 16'h0009, 16'hABCD, 16'h0000);
        chk("ss_lo_wr", mem_memWrite, 1);
        chk("ss_lo_be", mem_byte_en, 1);
        chk("ss_lo_addr", mem_address, 16'h0009);
        chk("ss_lo_data", mem_writeData, 16'hABCD);
        @(negedge clk);
        chk("ss_hi_wr", mem_memWrite, 1);
        chk("ss_hi_addr", mem_address, 16'h000A);
        chk("ss_hi_data", mem_writeData, 16'h00AB);
        @(negedge clk);
        chk("ss_ready", ready, 1);
        chk("ss_wr_off", mem_memWrite, 0);
        chk("ss_addr_hold", mem_address, 16'h000A);
        chk("ss_loaddata_hold", loadData, 16'h5600);
        chk("ss_mem9", mem[16'h0009], 16'h00CD);
        chk("ss_memA", mem[16'h000A], 16'h00AB);

        // Read back the split store.
        issue(1, 0, 0, 16'h0009, 16'h0000, 16'hABCD);

        // Aligned store 1234 at 0010, then read it back.
        issue(0, 1, 0, 16'h0010, 16'h1234, 16'h0000);
        chk("as_wr", mem_memWrite, 1);
        chk("as_be", mem_byte_en, 0);
        @(negedge clk);
        chk("as_ready", ready, 1);
        issue(1, 0, 0, 16'h0010, 16'h0000, 16'h1234);
        @(negedge clk);
        @(negedge clk);

        // Illegal request: both read and write.
        issue(1, 1, 0, 16'h0020, 16'hFFFF, 16'h0000);
        chk("il_reqErr", reqErr, 1);
        chk("il_ready", ready, 1);
        chk("il_wr", mem_memWrite, 0);
        @(negedge clk);
        chk("il_reqErr_off", reqErr, 0);

        // Ignored request: neither set.
        issue(0, 0, 0, 16'h0030, 16'hFFFF, 16'h0000);
        chk("ig_ready", ready, 1);
        chk("ig_reqErr", reqErr, 0);
        chk("ig_be", mem_byte_en, 0);
        chk("ig_wr", mem_memWrite, 0);

        // Reset in ACC_HI of a split load.
        issue(1, 0, 0, 16'h0005, 16'h0000, 16'hDE43);
        @(negedge clk);
        chk("mr_hi_addr", mem_address, 16'h0006);
        void'(exp_q.pop_back());
        #2 reset = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        chk("midrst_valid", loadValid, 0);
        reset = 1'b1;
        @(negedge clk);
        issue(1, 0, 0, 16'h0000, 16'h0000, 16'h3856);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
